// File: rtl/seq_finder_pkg.sv
// Shared helpers for the serial pattern finder: progress width and the
// pattern's longest proper border (the progress value right after a match).
package seq_finder_pkg;

  localparam int PAT_W_MAX = 32;

  // Width needed to hold a value in 0..pat_w (used for fill and progress).
  function automatic int prog_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // Longest k < pat_w such that the last k pattern bits equal the first k.
  function automatic int longest_border(input logic [PAT_W_MAX-1:0] pat,
                                        input int pat_w);
    int   best;
    logic ok;
    best = 0;
    for (int k = 1; k < pat_w; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pat[i] != pat[pat_w-k+i]) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

endpackage

// File: rtl/seq_prefix_len.sv
// Combinational prefix tracker: longest pattern prefix that equals the
// suffix of the received history, limited by how many bits are held.
module seq_prefix_len
  import seq_finder_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101
) (
  input  logic [PAT_W-2:0]             hist,
  input  logic [prog_width(PAT_W)-1:0] fill,
  output logic [prog_width(PAT_W)-1:0] progress
);

  localparam int PW = prog_width(PAT_W);

  logic [PAT_W-1:1] cand;

  // One comparator per candidate length; a full-length match is never progress.
  for (genvar k = 1; k < PAT_W; k++) begin : g_cand
    localparam logic [PW-1:0] K = PW'(k);
    assign cand[k] = (fill >= K) && (hist[k-1:0] == PATTERN[PAT_W-1 -: k]);
  end

  always_comb begin
    progress = '0;
    for (int k = 1; k < PAT_W; k++) begin
      if (cand[k]) progress = PW'(k);
    end
  end

endmodule

// File: rtl/seq_pattern_finder.sv
// Serial detector for a compile-time bit pattern (MSB received first), with
// overlap/non-overlap modes, a saturating match counter and prefix progress.
module seq_pattern_finder
  import seq_finder_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic                         in_bit,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic [prog_width(PAT_W)-1:0] progress
);

  localparam int            PW     = prog_width(PAT_W);
  localparam logic [PW-1:0] FULL   = PW'(PAT_W);
  localparam int            BORDER = longest_border(32'(PATTERN), PAT_W);

  // Handshake: in_valid qualifies in_bit on the rising edge of clk. There is
  // no ready; every valid bit is accepted unless clear is high the same cycle.

  logic [PAT_W-1:0] hist;
  logic [PW-1:0]    fill;
  logic [PAT_W-1:0] hist_n;
  logic [PW-1:0]    fill_n;
  logic             hit;
  logic             cnt_full;

  always_comb begin
    hist_n   = {hist[PAT_W-2:0], in_bit};
    fill_n   = (fill == FULL) ? fill : fill + PW'(1);
    hit      = (fill_n == FULL) && (hist_n == PATTERN);
    cnt_full = &match_count;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist        <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else if (clear) begin
      hist        <= '0;
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else if (in_valid) begin
      hist  <= hist_n;
      // Non-overlap mode forgets the matched bits but keeps hist for progress.
      fill  <= (hit && !OVERLAP) ? '0 : fill_n;
      match <= hit;
      if (hit && !cnt_full) match_count <= match_count + CNT_W'(1);
    end else begin
      match <= 1'b0;
    end
  end

  seq_prefix_len #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_prefix (
    .hist     (hist[PAT_W-2:0]),
    .fill     (fill),
    .progress (progress)
  );

  // While match is high the history holds exactly the pattern, so in overlap
  // mode the progress must equal the pattern's longest proper border.
  a_match_hist: assert property (@(posedge clk) disable iff (!rst_n)
    match |-> (hist == PATTERN));
  a_match_border: assert property (@(posedge clk) disable iff (!rst_n)
    (match && OVERLAP) |-> (progress == PW'(BORDER)));

endmodule

// File: tb/tb_seq_pattern_finder.sv
// Bench for seq_pattern_finder: three configurations share one stimulus
// stream and are compared against a bit-queue reference model.
module tb_seq_pattern_finder;

  localparam int         P_W = 4;
  localparam logic [3:0] PAT = 4'b1101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;

  logic       m0, m1, m2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [2:0] p0, p1, p2;

  always #5 clk = ~clk;

  // dut0: defaults; dut1: non-overlapping; dut2: 2-bit counter.
  seq_pattern_finder #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .match(m0), .match_count(c0), .progress(p0));
  seq_pattern_finder #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .match(m1), .match_count(c1), .progress(p1));
  seq_pattern_finder #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_bit(in_bit),
    .match(m2), .match_count(c2), .progress(p2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // seen: bits received since the last reset/clear/non-overlap match, newest at [0].
  bit [P_W-1:0] pat_v = PAT;
  bit [127:0]   seen[3];
  int           len[3];
  int           cnt[3];
  bit           exp_m[3];
  logic [7:0]   exp_q0[$];
  logic [7:0]   exp_q1[$];
  logic [7:0]   exp_q2[$];

  function automatic int cmax(input int m);
    return (m == 2) ? 3 : 255;
  endfunction

  function automatic bit ovl(input int m);
    return (m != 1);
  endfunction

  function automatic int model_progress(input int m);
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k < P_W; k++) begin
      if (k <= len[m]) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          if (seen[m][k-1-i] != pat_v[P_W-1-i]) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  task automatic push_exp(input int m, input int v);
    case (m)
      0: exp_q0.push_back(8'(v));
      1: exp_q1.push_back(8'(v));
      default: exp_q2.push_back(8'(v));
    endcase
  endtask

  task automatic model_clear(input int m);
    seen[m]  = '0;
    len[m]   = 0;
    cnt[m]   = 0;
    exp_m[m] = 1'b0;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) model_clear(m);
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
  endtask

  task automatic model_edge(input bit v, input bit b, input bit c);
    bit hit;
    for (int m = 0; m < 3; m++) begin
      if (c) begin
        model_clear(m);
      end else if (v) begin
        seen[m] = {seen[m][126:0], b};
        len[m]++;
        hit = (len[m] >= P_W) && (seen[m][P_W-1:0] == pat_v);
        exp_m[m] = hit;
        if (hit) begin
          if (cnt[m] < cmax(m)) cnt[m]++;
          push_exp(m, cnt[m]);
          if (!ovl(m)) len[m] = 0;
        end
      end else begin
        exp_m[m] = 1'b0;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic sb_pop(input string name, input int m, input logic [31:0] act);
    logic [7:0] e;
    int sz;
    sz = (m == 0) ? exp_q0.size() : (m == 1) ? exp_q1.size() : exp_q2.size();
    if (sz == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: match with count %0d, expected no match", name, act);
    end else begin
      case (m)
        0: e = exp_q0.pop_front();
        1: e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      check(name, act, 32'(e));
    end
  endtask

  always @(negedge clk) begin
    check("match0", 32'(m0), 32'(exp_m[0]));
    check("match1", 32'(m1), 32'(exp_m[1]));
    check("match2", 32'(m2), 32'(exp_m[2]));
    check("prog0", 32'(p0), 32'(model_progress(0)));
    check("prog1", 32'(p1), 32'(model_progress(1)));
    check("prog2", 32'(p2), 32'(model_progress(2)));
    check("count0", 32'(c0), 32'(cnt[0]));
    check("count1", 32'(c1), 32'(cnt[1]));
    check("count2", 32'(c2), 32'(cnt[2]));
    if (m0 === 1'b1) sb_pop("sb_count0", 0, 32'(c0));
    if (m1 === 1'b1) sb_pop("sb_count1", 1, 32'(c1));
    if (m2 === 1'b1) sb_pop("sb_count2", 2, 32'(c2));
  end

  // ---------------- driver ----------------
  task automatic step(input bit v, input bit b, input bit c);
    in_valid = v;
    in_bit   = b;
    clear    = c;
    @(posedge clk);
    #1;
    model_edge(v, b, c);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    logic [15:0] bv;
    bv = bits;
    for (int i = n - 1; i >= 0; i--) step(1'b1, bv[i], 1'b0);
  endtask

  bit seq_a[4]  = '{1, 1, 0, 1};
  int prog_a[4] = '{1, 2, 3, 1};
  int sat_a[5]  = '{1, 2, 3, 3, 3};

  initial begin
    int pulses;
    logic [15:0] sat_bits;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_match", 32'(m0), 0);
    check("reset_count", 32'(c0), 0);
    check("reset_prog", 32'(p0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic match
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq_a[i], 1'b0);
      check("basic_prog", 32'(p0), 32'(prog_a[i]));
    end
    check("basic_match", 32'(m0), 1);
    check("basic_count", 32'(c0), 1);
    step(1'b0, 1'b0, 1'b0);
    check("basic_pulse_end", 32'(m0), 0);

    // overlap vs non-overlap on 1101101
    step(1'b0, 1'b0, 1'b1);
    send_bits(16'b1101, 4);
    check("novl_first_match", 32'(m1), 1);
    send_bits(16'b101, 3);
    check("ovl_second_match", 32'(m0), 1);
    check("ovl_count", 32'(c0), 2);
    check("novl_no_match", 32'(m1), 0);
    check("novl_count", 32'(c1), 1);
    check("novl_prog", 32'(p1), 1);

    // in_valid gaps
    step(1'b0, 1'b0, 1'b1);
    send_bits(16'b11, 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      check("gap_match", 32'(m0), 0);
      check("gap_prog", 32'(p0), 2);
    end
    send_bits(16'b01, 2);
    check("gap_final_match", 32'(m0), 1);
    check("gap_count", 32'(c0), 1);

    // clear mid-pattern drops the bit presented with it
    step(1'b0, 1'b0, 1'b1);
    send_bits(16'b110, 3);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    check("clear_match", 32'(m0), 0);
    check("clear_count", 32'(c0), 0);
    check("clear_prog", 32'(p0), 1);

    // saturation on the 2-bit counter
    step(1'b0, 1'b0, 1'b1);
    sat_bits = 16'b1101_101_101_101_101;
    pulses = 0;
    for (int i = 15; i >= 0; i--) begin
      step(1'b1, sat_bits[i], 1'b0);
      if (m2 === 1'b1) begin
        if (pulses < 5) check("sat_count", 32'(c2), 32'(sat_a[pulses]));
        pulses++;
      end
    end
    check("sat_pulses", 32'(pulses), 5);
    check("sat_wide_count", 32'(c0), 5);

    // async reset between edges
    send_bits(16'b110, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", 32'(c0), 0);
    check("arst_match", 32'(m0), 0);
    check("arst_prog", 32'(p0), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    check("arst_after_match", 32'(m0), 0);
    check("arst_after_prog", 32'(p0), 1);

    // randomized stream
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0));
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("sb_drain0", 32'(exp_q0.size()), 0);
    check("sb_drain1", 32'(exp_q1.size()), 0);
    check("sb_drain2", 32'(exp_q2.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
